s_to_p_converter: RTL

//  Serial-to-parallel frame assembler: gathers SERIAL_LENGTH x 32-bit words per input beat into a

---
 rtl/aff3ct_pkg.sv | 14 +
 rtl/s_to_p_fill_stage.sv | 45 ++++
 rtl/s_to_p_converter.sv | 79 +++++++
 3 files changed

// File: rtl/aff3ct_pkg.sv
// Shared word/counter definitions for the frame converters.
package aff3ct_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Bits needed to address n frame slots; a single-slot frame still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s_to_p_fill_stage.sv
// Fill bank: places accepted beats at the running index and flags the beat that completes a frame.
module s_to_p_fill_stage
    import aff3ct_pkg::*;
#(
    parameter int PARALLEL_LENGTH = 32,
    parameter int SERIAL_LENGTH   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  accept,
    input  logic [0:SERIAL_LENGTH-1][WORD_W-1:0]  idata,
    output logic                                  frame_done,
    output logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] merged,
    output logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] fbuf
);

    localparam int               IDX_W = idx_width(PARALLEL_LENGTH);
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(SERIAL_LENGTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PARALLEL_LENGTH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next   = cnt + STEP;
    assign frame_done = accept && (cnt_next == LAST);

    // merged is the fill bank as it will look once this beat lands, so a completing
    // frame can bypass fbuf and go straight to the hold bank.
    always_comb begin
        merged = fbuf;
        for (int i = 0; i < SERIAL_LENGTH; i++) begin
            merged[IDX_W'(cnt + CNT_W'(i))] = idata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt  <= frame_done ? '0 : cnt_next;
            fbuf <= merged;
        end
    end

endmodule

// File: rtl/s_to_p_converter.sv
// Serial-to-parallel frame assembler with a fill bank and a hold bank so assembly
// keeps going while the consumer stalls with fct.
module s_to_p_converter
    import aff3ct_pkg::*;
#(
    parameter int PARALLEL_LENGTH = 32,
    parameter int SERIAL_LENGTH   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ien,
    input  logic [0:SERIAL_LENGTH-1][WORD_W-1:0]   idata,
    input  logic                                   fct,
    output logic                                   oen,
    output logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] odata,
    output logic                                   full
);

    if ((SERIAL_LENGTH < 1) || (SERIAL_LENGTH > PARALLEL_LENGTH) ||
        (PARALLEL_LENGTH > 65535) || ((PARALLEL_LENGTH % SERIAL_LENGTH) != 0)) begin : g_param_check
        $error("s_to_p_converter: PARALLEL_LENGTH must be a multiple of SERIAL_LENGTH, 1 <= S <= P <= 65535");
    end

    logic                                   accept;
    logic                                   drain;
    logic                                   hold_free;
    logic                                   frame_done;
    logic                                   ovalid;
    logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] obuf;
    logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] merged;
    logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] fbuf;

    // full doubles as the "fill bank holds a finished frame" flag.
    assign accept    = ien && !full;
    assign drain     = ovalid && !fct;
    assign hold_free = !ovalid || drain;

    s_to_p_fill_stage #(
        .PARALLEL_LENGTH (PARALLEL_LENGTH),
        .SERIAL_LENGTH   (SERIAL_LENGTH)
    ) u_fill (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .idata      (idata),
        .frame_done (frame_done),
        .merged     (merged),
        .fbuf       (fbuf)
    );

    // A waiting fill-bank frame and a completing beat never coincide, since full
    // blocks beats; either one refills the hold bank when it empties this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid <= 1'b0;
            full   <= 1'b0;
            oen    <= 1'b0;
            odata  <= '0;
        end else begin
            oen <= drain;
            if (drain) begin
                odata <= obuf;
            end
            if (full && hold_free) begin
                obuf   <= fbuf;
                ovalid <= 1'b1;
                full   <= 1'b0;
            end else if (frame_done && hold_free) begin
                obuf   <= merged;
                ovalid <= 1'b1;
            end else if (frame_done) begin
                full <= 1'b1;
            end else if (drain) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule
